mips_mc_control: RTL and testbench

- Main control FSM of the multicycle MIPS core.
- Sequences the shared datapath registers (PC, IR, MDR, A/B, ALUOut) and the register file by driving their load enables and mux selects each cycle.
- Instruction set covered: lw, sw, R-type, beq, addi, j. Each instruction takes 3-5 cycles.
- Moore-style: control outputs decode from the state register only. The exception is pc_en, which also uses the ALU zero flag.

---
 rtl/mips_mc_pkg.sv | 60 ++++++
 rtl/mips_mc_out_decode.sv | 62 ++++++
 rtl/mips_mc_control.sv | 110 +++++++++++
 tb/tb_mips_mc_control.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes,
// mux-select codes and the control-word layout produced by the decoder.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_out_decode.sv
// Moore output decode: maps the raw state code to the datapath control word.
// Unused encodings 12-15 decode to an all-zero word.
module mips_mc_out_decode
  import mips_mc_pkg::*;
(
  input  logic [3:0] st_code,
  output ctrl_t      ctl
);

  always_comb begin
    ctl = '0;
    case (st_code)
      S_FETCH: begin
        ctl.ir_write  = 1'b1;
        ctl.pc_write  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEMRD: ctl.iord = 1'b1;
      S_MEMWR: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
      end
      S_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
      end
      S_ADDIWB: ctl.reg_write = 1'b1;
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = PCSRC_ALUOUT;
        ctl.branch    = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_src   = PCSRC_JUMP;
        ctl.pc_write = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS core (lw, sw, R-type, beq, addi, j).
// Define MC_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            iord,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            illegal_op,
  output logic [ST_W-1:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       mem_go;
  ctrl_t      dec_ctl;
  ctrl_t      ctl;

`ifdef MC_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // opcode is re-sampled here to pick the load or store path
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:   state_d = mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_go ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  mips_mc_out_decode u_decode (
    .st_code (state_q),
    .ctl     (dec_ctl)
  );

  // Reset masks the whole word even though the register already reads FETCH.
  always_comb begin
    ctl = dec_ctl;
    if ((state_q == S_FETCH) && !mem_go) begin
      ctl.ir_write = 1'b0;
      ctl.pc_write = 1'b0;
    end
    if (rst) ctl = '0;
  end

  assign pc_en      = ctl.pc_write | (ctl.branch & zero);
  assign iord       = ctl.iord;
  assign mem_write  = ctl.mem_write;
  assign ir_write   = ctl.ir_write;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_write  = ctl.reg_write;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign pc_src     = ctl.pc_src;
  assign illegal_op = !rst && (state_q == S_DECODE) && !op_known(opcode[5:0]);
  assign state      = ST_W'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed, table-driven bench for the multicycle MIPS main control FSM.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mips_mc_control #(.OP_W(6), .ST_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Word layout: pc_en iord mem_write ir_write | reg_dst mem_to_reg reg_write alu_src_a
  //              | alu_src_b | alu_op | pc_src | illegal_op
  localparam logic [14:0] W_ZERO    = 15'b0000_0000_00_00_00_0;
  localparam logic [14:0] W_FETCH   = 15'b1001_0000_01_00_00_0;
  localparam logic [14:0] W_FETCH_S = 15'b0000_0000_01_00_00_0;
  localparam logic [14:0] W_DECODE  = 15'b0000_0000_11_00_00_0;
  localparam logic [14:0] W_DEC_ILL = 15'b0000_0000_11_00_00_1;
  localparam logic [14:0] W_MEMADR  = 15'b0000_0001_10_00_00_0;
  localparam logic [14:0] W_MEMRD   = 15'b0100_0000_00_00_00_0;
  localparam logic [14:0] W_MEMWR   = 15'b0110_0000_00_00_00_0;
  localparam logic [14:0] W_MEMWB   = 15'b0000_0110_00_00_00_0;
  localparam logic [14:0] W_EXECUTE = 15'b0000_0001_00_10_00_0;
  localparam logic [14:0] W_ALUWB   = 15'b0000_1010_00_00_00_0;
  localparam logic [14:0] W_ADDIWB  = 15'b0000_0010_00_00_00_0;
  localparam logic [14:0] W_BR_TAKE = 15'b1000_0001_00_01_01_0;
  localparam logic [14:0] W_BR_NOT  = 15'b0000_0001_00_01_01_0;
  localparam logic [14:0] W_JUMP    = 15'b1000_0000_00_00_10_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        z;
    logic [3:0]  st;
    logic [14:0] ctl;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] ctl_word();
    return {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
  endfunction

  task automatic add(input string nm, input logic [5:0] op, input logic z,
                     input logic [3:0] st, input logic [14:0] c);
    vec_t v;
    v.name = nm; v.op = op; v.z = z; v.st = st; v.ctl = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [3:0] exp_st, input logic [14:0] exp_ctl);
    logic [14:0] got;
    got = ctl_word();
    n_checks++;
    if (state !== exp_st) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", nm, state, exp_st);
    end
    n_checks++;
    if (got !== exp_ctl) begin
      n_fail++;
      $display("FAIL %s ctrl: got %b expected %b", nm, got, exp_ctl);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    add("lw_fetch", LW, 0, 4'd0, W_FETCH);   add("lw_decode", LW, 0, 4'd1, W_DECODE);
    add("lw_memadr", LW, 0, 4'd2, W_MEMADR); add("lw_memrd", LW, 0, 4'd3, W_MEMRD);
    add("lw_memwb", LW, 0, 4'd4, W_MEMWB);
    add("sw_fetch", SW, 0, 4'd0, W_FETCH);   add("sw_decode", SW, 0, 4'd1, W_DECODE);
    add("sw_memadr", SW, 0, 4'd2, W_MEMADR); add("sw_memwr", SW, 0, 4'd5, W_MEMWR);
    add("rt_fetch", RT, 0, 4'd0, W_FETCH);   add("rt_decode", RT, 0, 4'd1, W_DECODE);
    add("rt_exec", RT, 0, 4'd6, W_EXECUTE);  add("rt_aluwb", RT, 0, 4'd7, W_ALUWB);
    add("addi_fetch", ADDI, 0, 4'd0, W_FETCH); add("addi_decode", ADDI, 0, 4'd1, W_DECODE);
    add("addi_ex", ADDI, 0, 4'd9, W_MEMADR);   add("addi_wb", ADDI, 0, 4'd10, W_ADDIWB);
    add("beq1_fetch", BEQ, 1, 4'd0, W_FETCH);  add("beq1_decode", BEQ, 1, 4'd1, W_DECODE);
    add("beq1_branch", BEQ, 1, 4'd8, W_BR_TAKE);
    add("beq0_fetch", BEQ, 0, 4'd0, W_FETCH);  add("beq0_decode", BEQ, 0, 4'd1, W_DECODE);
    add("beq0_branch", BEQ, 0, 4'd8, W_BR_NOT);
    add("j_fetch", JMP, 0, 4'd0, W_FETCH);     add("j_decode", JMP, 0, 4'd1, W_DECODE);
    add("j_jump", JMP, 0, 4'd11, W_JUMP);
    add("ill_fetch", BAD, 0, 4'd0, W_FETCH);   add("ill_decode", BAD, 0, 4'd1, W_DEC_ILL);
    add("ill_back", LW, 0, 4'd0, W_FETCH);

    // Reset held across edges: FETCH state with every output masked.
    repeat (2) @(negedge clk);
    #1;
    check("reset_hold", 4'd0, W_ZERO);
    rst = 1'b0;

    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      zero   = vecs[i].z;
      #1;
      check(vecs[i].name, vecs[i].st, vecs[i].ctl);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a load's MEMRD cycle.
    opcode = LW; zero = 1'b0;
    #1; check("rs_decode", 4'd1, W_DECODE);
    @(negedge clk); #1; check("rs_memadr", 4'd2, W_MEMADR);
    @(negedge clk); #1; check("rs_memrd", 4'd3, W_MEMRD);
    #2; rst = 1'b1;
    #1; check("rs_async", 4'd0, W_ZERO);
    @(negedge clk); #1; check("rs_held", 4'd0, W_ZERO);
    rst = 1'b0;
    #1; check("rs_release", 4'd0, W_FETCH);
    @(negedge clk); #1; check("rs_first_edge", 4'd1, W_DECODE);

    // Store with memory handshake.
    opcode = SW; mem_ready = 1'b1;
    @(negedge clk); #1; check("mw_memadr", 4'd2, W_MEMADR);
    @(negedge clk);
`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1; check($sformatf("mw_wait%0d", k), 4'd5, W_MEMWR);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1; check("mw_ready", 4'd5, W_MEMWR);
    @(negedge clk);
    mem_ready = 1'b0;
    #1; check("mw_fetch_stall", 4'd0, W_FETCH_S);
    @(negedge clk); #1; check("mw_fetch_hold", 4'd0, W_FETCH_S);
    mem_ready = 1'b1;
    #1; check("mw_fetch_go", 4'd0, W_FETCH);
    @(negedge clk); #1; check("mw_decode", 4'd1, W_DECODE);
`else
    mem_ready = 1'b0;
    #1; check("mw_memwr_ign", 4'd5, W_MEMWR);
    @(negedge clk); #1; check("mw_fetch_ign", 4'd0, W_FETCH);
    @(negedge clk); #1; check("mw_decode_ign", 4'd1, W_DECODE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
